// File: rtl/alu_op_sequencer.sv
// Sequences the 4-bit ALU / 8-bit accumulator datapath through a buffered program of up
// to DEPTH {func, A} entries. Optional macro ALU_OP_SEQUENCER_AUTOCLR_EN adds a CLEAR state.
module alu_op_sequencer #(
   parameter int DEPTH  = 4,
   parameter int FUNC_W = 3,
   parameter int A_W    = 4,
   parameter int ACC_W  = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              wr_en,
   input  logic [FUNC_W-1:0] wr_func,
   input  logic [A_W-1:0]    wr_a,
   output logic              full,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic [FUNC_W-1:0] alu_func,
   output logic [A_W-1:0]    alu_a,
   output logic              reg_en,
   output logic              reg_clr,
   input  logic [ACC_W-1:0]  acc_q,
   output logic [2:0]        dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [FUNC_W-1:0] FUNC_HOLD = {FUNC_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
`ifdef ALU_OP_SEQUENCER_AUTOCLR_EN
      S_CLEAR   = 3'd1,
`endif
      S_ISSUE   = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ACC_W-1:0]   result_q, result_d;
   logic               rst_clr_q;
   logic [FUNC_W-1:0]  func_mem_q [DEPTH];
   logic [A_W-1:0]     a_mem_q    [DEPTH];
   logic               wr_accept;
   logic               clr_fsm;

   // Handshake: wr_en and start are single-cycle requests with no ready/ack. A write is
   // taken only when IDLE and !full; start only when IDLE with a non-empty program.
   // Callers observe full/busy to know whether a request will be honoured.
   assign wr_accept = wr_en && (state_q == S_IDLE) && !full;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign result    = result_q;
   assign reg_clr   = rst_clr_q | clr_fsm;
   assign dbg_state = state_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         result_q  <= '0;
         rst_clr_q <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            func_mem_q[i] <= '0;
            a_mem_q[i]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         result_q  <= result_d;
         rst_clr_q <= 1'b0;
         if (wr_accept) begin
            func_mem_q[count_q[PTR_W-1:0]] <= wr_func;
            a_mem_q[count_q[PTR_W-1:0]]    <= wr_a;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      result_d = result_q;
      busy     = 1'b1;
      done     = 1'b0;
      reg_en   = 1'b0;
      clr_fsm  = 1'b0;
      alu_func = FUNC_HOLD;
      alu_a    = '0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (wr_accept) begin
               count_d = count_q + CNT_W'(1);
            end
            // A write in the same cycle as start counts toward the program.
            if (start && ((count_q != '0) || wr_accept)) begin
               rd_ptr_d = '0;
`ifdef ALU_OP_SEQUENCER_AUTOCLR_EN
               state_d  = S_CLEAR;
`else
               state_d  = S_ISSUE;
`endif
            end
         end
`ifdef ALU_OP_SEQUENCER_AUTOCLR_EN
         S_CLEAR: begin
            clr_fsm = 1'b1;
            state_d = S_ISSUE;
         end
`endif
         S_ISSUE: begin
            alu_func = func_mem_q[rd_ptr_q];
            alu_a    = a_mem_q[rd_ptr_q];
            reg_en   = 1'b1;
            state_d  = S_CAPTURE;
         end
         S_CAPTURE: begin
            alu_func = func_mem_q[rd_ptr_q];
            alu_a    = a_mem_q[rd_ptr_q];
            if (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1))) begin
               state_d = S_DONE;
            end else begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               state_d  = S_ISSUE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            result_d = acc_q;
            count_d  = '0;
            rd_ptr_d = '0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: models the ALU plus 8-bit register (B = low nibble
// of the register) and checks issue timing, done latency and results per scenario.
module tb_alu_op_sequencer;

`ifdef ALU_OP_SEQUENCER_AUTOCLR_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_func = 3'd0;
   logic [3:0]  wr_a = 4'd0;
   logic        start = 1'b0;
   logic        full, busy, done, reg_en, reg_clr;
   logic [7:0]  result;
   logic [2:0]  alu_func;
   logic [3:0]  alu_a;
   logic [2:0]  dbg_state;
   logic [7:0]  acc;
   logic        preload_en = 1'b0;
   logic [7:0]  preload_val = 8'h00;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] en_mask, done_mask, clr_mask, busy_mask;
   logic [27:0] iss_trace;
   logic [2:0]  cap_func;
   logic [3:0]  cap_a;

   alu_op_sequencer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .wr_en     (wr_en),
      .wr_func   (wr_func),
      .wr_a      (wr_a),
      .full      (full),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .alu_func  (alu_func),
      .alu_a     (alu_a),
      .reg_en    (reg_en),
      .reg_clr   (reg_clr),
      .acc_q     (acc),
      .dbg_state (dbg_state)
   );

   always #5 Clock = ~Clock;

   function automatic logic [7:0] alu_model(input logic [2:0] f, input logic [3:0] a, input logic [7:0] r);
      logic [7:0] b;
      b = {4'd0, r[3:0]};
      case (f)
         3'd0, 3'd1: return {4'd0, a} + b;
         3'd6:       return {4'd0, a} * b;
         default:    return r;
      endcase
   endfunction

   // External ALU + accumulator register driven by the sequencer.
   always @(posedge Clock) begin
      if (reg_clr === 1'b1)         acc <= 8'h00;
      else if (reg_en === 1'b1)     acc <= alu_model(alu_func, alu_a, acc);
      else if (preload_en === 1'b1) acc <= preload_val;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic write_entry(input logic [2:0] f, input logic [3:0] a);
      wr_en = 1'b1;
      wr_func = f;
      wr_a = a;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic preload(input logic [7:0] v);
      preload_en = 1'b1;
      preload_val = v;
      tick();
      preload_en = 1'b0;
   endtask

   // Start is high in cycle 0 (and through cycle 'hold'); cycles 1..max_c are recorded.
   task automatic run_program(input logic with_wr, input logic [2:0] f, input logic [3:0] a,
                              input int hold, input int max_c);
      en_mask = '0;
      done_mask = '0;
      clr_mask = '0;
      busy_mask = '0;
      iss_trace = '0;
      cap_func = '0;
      cap_a = '0;
      start = 1'b1;
      if (with_wr) begin
         wr_en = 1'b1;
         wr_func = f;
         wr_a = a;
      end
      tick();
      wr_en = 1'b0;
      for (int c = 1; c <= max_c; c++) begin
         start = (c <= hold);
         en_mask[c] = reg_en;
         done_mask[c] = done;
         clr_mask[c] = reg_clr;
         busy_mask[c] = busy;
         if (reg_en === 1'b1) iss_trace = {iss_trace[20:0], alu_func, alu_a};
         if (c == 2) begin
            cap_func = alu_func;
            cap_a = alu_a;
         end
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
      n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %0h expected 0", result); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b expected 0", full); end
      n_cmp++; if (alu_func !== 3'd7) begin n_err++; $display("FAIL reset_alu_func: got %0d expected 7", alu_func); end
      n_cmp++; if (alu_a !== 4'd0) begin n_err++; $display("FAIL reset_alu_a: got %0d expected 0", alu_a); end
      n_cmp++; if (reg_en !== 1'b0) begin n_err++; $display("FAIL reset_reg_en: got %0b expected 0", reg_en); end
      n_cmp++; if (reg_clr !== 1'b1) begin n_err++; $display("FAIL reset_reg_clr: got %0b expected 1", reg_clr); end
      Reset = 1'b0;
      tick();
      n_cmp++; if (reg_clr !== 1'b0) begin n_err++; $display("FAIL reset_reg_clr_drop: got %0b expected 0", reg_clr); end
   endtask

   task automatic test_basic();
      write_entry(3'd1, 4'd3);
      write_entry(3'd1, 4'd5);
      write_entry(3'd6, 4'd2);
      run_program(1'b0, 3'd0, 4'd0, 0, 10);
      n_cmp++; if (en_mask !== (32'h2A << OFF)) begin n_err++; $display("FAIL basic_reg_en_cycles: got %0h expected %0h", en_mask, 32'h2A << OFF); end
      n_cmp++; if (done_mask !== (32'h80 << OFF)) begin n_err++; $display("FAIL basic_done_cycle: got %0h expected %0h", done_mask, 32'h80 << OFF); end
      n_cmp++; if (busy_mask !== ((32'h1 << (8 + OFF)) - 32'h2)) begin n_err++; $display("FAIL basic_busy_cycles: got %0h expected %0h", busy_mask, (32'h1 << (8 + OFF)) - 32'h2); end
      n_cmp++; if (clr_mask !== ((OFF != 0) ? 32'h2 : 32'h0)) begin n_err++; $display("FAIL basic_reg_clr_cycles: got %0h", clr_mask); end
      n_cmp++; if (iss_trace[20:0] !== {3'd1, 4'd3, 3'd1, 4'd5, 3'd6, 4'd2}) begin n_err++; $display("FAIL basic_issue_trace: got %0h", iss_trace); end
      n_cmp++; if (result !== 8'h10) begin n_err++; $display("FAIL basic_result: got %0h expected 10", result); end
      if (OFF == 0) begin
         n_cmp++; if ({cap_func, cap_a} !== {3'd1, 4'd3}) begin n_err++; $display("FAIL basic_capture_hold: got %0h expected 13", {cap_func, cap_a}); end
      end
   endtask

   task automatic test_full();
      do_reset();
      write_entry(3'd1, 4'd1);
      write_entry(3'd1, 4'd2);
      write_entry(3'd1, 4'd3);
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_three: got %0b expected 0", full); end
      write_entry(3'd1, 4'd4);
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_four: got %0b expected 1", full); end
      write_entry(3'd1, 4'd7);
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_after_fifth: got %0b expected 1", full); end
      run_program(1'b0, 3'd0, 4'd0, 0, 12);
      n_cmp++; if (en_mask !== (32'hAA << OFF)) begin n_err++; $display("FAIL full_reg_en_cycles: got %0h expected %0h", en_mask, 32'hAA << OFF); end
      n_cmp++; if (done_mask !== (32'h200 << OFF)) begin n_err++; $display("FAIL full_done_cycle: got %0h expected %0h", done_mask, 32'h200 << OFF); end
      n_cmp++; if (iss_trace !== {3'd1, 4'd1, 3'd1, 4'd2, 3'd1, 4'd3, 3'd1, 4'd4}) begin n_err++; $display("FAIL full_issue_trace: got %0h", iss_trace); end
      n_cmp++; if (result !== 8'h0A) begin n_err++; $display("FAIL full_result: got %0h expected 0a", result); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_emptied: got %0b expected 0", full); end
   endtask

   task automatic test_wr_start();
      do_reset();
      write_entry(3'd1, 4'd2);
      run_program(1'b1, 3'd6, 4'd3, 0, 8);
      n_cmp++; if (en_mask !== (32'hA << OFF)) begin n_err++; $display("FAIL wrstart_reg_en_cycles: got %0h expected %0h", en_mask, 32'hA << OFF); end
      n_cmp++; if (done_mask !== (32'h20 << OFF)) begin n_err++; $display("FAIL wrstart_done_cycle: got %0h expected %0h", done_mask, 32'h20 << OFF); end
      n_cmp++; if (iss_trace[13:0] !== {3'd1, 4'd2, 3'd6, 4'd3}) begin n_err++; $display("FAIL wrstart_issue_trace: got %0h", iss_trace); end
      n_cmp++; if (result !== 8'h06) begin n_err++; $display("FAIL wrstart_result: got %0h expected 06", result); end
   endtask

   task automatic test_start_ignored();
      run_program(1'b0, 3'd0, 4'd0, 0, 6);
      n_cmp++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL empty_busy: got %0h expected 0", busy_mask); end
      n_cmp++; if (en_mask !== 32'h0) begin n_err++; $display("FAIL empty_reg_en: got %0h expected 0", en_mask); end
      n_cmp++; if (done_mask !== 32'h0) begin n_err++; $display("FAIL empty_done: got %0h expected 0", done_mask); end
      write_entry(3'd1, 4'd1);
      write_entry(3'd1, 4'd1);
      run_program(1'b0, 3'd0, 4'd0, 7, 12);
      n_cmp++; if (en_mask !== (32'hA << OFF)) begin n_err++; $display("FAIL restart_reg_en_cycles: got %0h expected %0h", en_mask, 32'hA << OFF); end
      n_cmp++; if (done_mask !== (32'h20 << OFF)) begin n_err++; $display("FAIL restart_done_cycle: got %0h expected %0h", done_mask, 32'h20 << OFF); end
      n_cmp++; if (busy_mask !== ((32'h1 << (6 + OFF)) - 32'h2)) begin n_err++; $display("FAIL restart_busy_cycles: got %0h expected %0h", busy_mask, (32'h1 << (6 + OFF)) - 32'h2); end
      n_cmp++; if (result !== ((OFF != 0) ? 8'h02 : 8'h08)) begin n_err++; $display("FAIL restart_result: got %0h", result); end
   endtask

   task automatic test_reset_mid();
      write_entry(3'd1, 4'd1);
      write_entry(3'd1, 4'd1);
      write_entry(3'd1, 4'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %0b expected 0", done); end
      n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL midreset_result: got %0h expected 0", result); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL midreset_full: got %0b expected 0", full); end
      n_cmp++; if (reg_en !== 1'b0) begin n_err++; $display("FAIL midreset_reg_en: got %0b expected 0", reg_en); end
      tick();
      run_program(1'b0, 3'd0, 4'd0, 0, 8);
      n_cmp++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL midreset_start_busy: got %0h expected 0", busy_mask); end
      n_cmp++; if (en_mask !== 32'h0) begin n_err++; $display("FAIL midreset_start_reg_en: got %0h expected 0", en_mask); end
      n_cmp++; if (done_mask !== 32'h0) begin n_err++; $display("FAIL midreset_start_done: got %0h expected 0", done_mask); end
   endtask

   task automatic test_autoclr();
      do_reset();
      write_entry(3'd1, 4'd4);
      preload(8'h0F);
      run_program(1'b0, 3'd0, 4'd0, 0, 8);
`ifdef ALU_OP_SEQUENCER_AUTOCLR_EN
      n_cmp++; if (clr_mask !== 32'h2) begin n_err++; $display("FAIL autoclr_reg_clr_cycle: got %0h expected 2", clr_mask); end
      n_cmp++; if (en_mask !== 32'h4) begin n_err++; $display("FAIL autoclr_reg_en_cycle: got %0h expected 4", en_mask); end
      n_cmp++; if (done_mask !== 32'h10) begin n_err++; $display("FAIL autoclr_done_cycle: got %0h expected 10", done_mask); end
      n_cmp++; if (result !== 8'h04) begin n_err++; $display("FAIL autoclr_result: got %0h expected 04", result); end
`else
      n_cmp++; if (clr_mask !== 32'h0) begin n_err++; $display("FAIL noclr_reg_clr: got %0h expected 0", clr_mask); end
      n_cmp++; if (en_mask !== 32'h2) begin n_err++; $display("FAIL noclr_reg_en_cycle: got %0h expected 2", en_mask); end
      n_cmp++; if (done_mask !== 32'h8) begin n_err++; $display("FAIL noclr_done_cycle: got %0h expected 8", done_mask); end
      n_cmp++; if (result !== 8'h13) begin n_err++; $display("FAIL noclr_result: got %0h expected 13", result); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wr_start();
      test_start_ignored();
      test_reset_mid();
      test_autoclr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
